dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the single-cycle core and an external host port (debug loader / DMA) used to preload and inspect data memory. Sits between the core's load/store path and `data_memory`. The core has priority. A buffered host request takes any cycle in which the core does not access memory. After `MAX_WAIT` consecutive busy cycles, the arbiter stalls the core for exactly one cycle to force the host access through.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, busy core cycles tolerated before a forced host slot (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `core_req` in 1: core uses memory this cycle (load or store)
- `core_we` in 1: core store enable
- `core_addr` in ADDR_W: ALU result address
- `core_wdata` in DATA_W: store data
- `core_rdata` out DATA_W: load data (= `mem_rdata`)
- `core_stall` out 1: freezes PC load and suppresses `RegWrite`/`MemWrite` this cycle
- `host_valid` in 1: host request valid
- `host_ready` out 1: request buffer empty
- `host_we` in 1: host write
- `host_addr` in ADDR_W: host address
- `host_wdata` in DATA_W: host write data
- `host_rsp_valid` out 1: one-cycle response pulse
- `host_rsp_data` out DATA_W: read data (0 for writes)
- `mem_we` out 1: to `data_memory` WE
- `mem_addr` out ADDR_W: to `data_memory` A
- `mem_wdata` out DATA_W: to `data_memory` WD
- `mem_rdata` in DATA_W: from `data_memory` RD (combinational read)

## Operation
- FSM states:
  - IDLE: no request pending.
  - PEND: request buffered, waiting for a slot.
  - FORCE: host owns memory and the core is stalled.
- Request capture: `host_valid && host_ready` at an edge captures `host_we`, `host_addr` and `host_wdata` into the buffer, clears `wait_cnt` and moves to PEND. `host_ready = (state == IDLE)`.
- Memory ownership by state:
  - IDLE: the core drives `mem_*`, and `mem_we = core_we & core_req`.
  - PEND with `core_req=0` (idle-slot steal): the buffer drives `mem_*`. The access is done, the state goes to IDLE and no stall occurs.
  - PEND with `core_req=1`: the core drives memory. If `wait_cnt == MAX_WAIT-1`, the state goes to FORCE; otherwise `wait_cnt` increments.
  - FORCE: `core_stall=1` and the buffer drives `mem_*`. The access is done and the state goes to IDLE. `core_we` is ignored.
- Response: for the edge that ends a host access, `host_rsp_valid` is registered high for one cycle. `host_rsp_data` is the `mem_rdata` sampled during the access for reads, and 0 for writes. There is no response backpressure.
- `wait_cnt` width is `$clog2(MAX_WAIT)`, minimum 1 bit. It never exceeds `MAX_WAIT-1`.
- The core owns memory in any cycle not listed above as a host access.

## Timing
- Reset values:
  - state IDLE, `wait_cnt` 0, buffer 0.
  - `host_rsp_valid` 0, `host_rsp_data` 0, `core_stall` 0, `host_ready` 1.
  - `mem_*` follow the core inputs.
- Best case: accept at edge N, core idle in cycle N+1, host access in N+1, `host_rsp_valid` in N+2.
- Worst case: accept at N, core busy for cycles N+1..N+MAX_WAIT, FORCE in cycle N+MAX_WAIT+1, response in N+MAX_WAIT+2. The core loses exactly one cycle per forced access.
- Back-to-back: `host_ready` rises in the response cycle, so the next request is accepted at the edge ending that cycle. The minimum host issue interval is 2 cycles.
- `core_stall` is a registered-state decode (state==FORCE) with no combinational path from `core_req`.
- Reset mid-operation: a buffered request is dropped with no response, and a pending `host_rsp_valid` is cleared.
- `host_valid` while `host_ready=0` is ignored. The host must hold the request.

## Configuration
- `DMEM_ARB_STATS_EN`: adds outputs `stat_steal_cnt` (16 bit) and `stat_force_cnt` (16 bit).
  - `stat_steal_cnt` counts idle-slot host accesses. `stat_force_cnt` counts FORCE cycles.
  - Both saturate at 0xFFFF and reset to 0.
- Without the macro, these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE/PEND/FORCE)
  - default width constants
  - the host request struct (`we`, `addr`, `wdata`)
- Sub-module `dmem_arb_req_buf` holds the one-entry request buffer with load/clear and a valid flag. The FSM, counter and muxes live in `dmem_arbiter`.

## Test plan
- Reset, then host write of 0xDEADBEEF to 0x10 with `core_req=0`: write happens in cycle N+1, `host_rsp_valid` in N+2 with data 0, `core_stall` never high.
- Host read of 0x10 while the core holds `core_req=1` continuously, `MAX_WAIT=8`: `core_stall` is high in exactly cycle N+9, and the response in N+10 carries 0xDEADBEEF.
- Core busy for 3 cycles and then idle: the host access steals the first idle cycle, there is no stall, and `stat_steal_cnt`=1 with the macro on.
- FORCE cycle with `core_we=1` to 0x20: memory at 0x20 is unchanged, and the host access completes.
- Assert `rst_n` low while in PEND: `host_ready`=1 immediately, and no `host_rsp_valid` pulse follows.
- Two back-to-back host requests with the core idle: responses arrive 2 cycles apart, and `host_ready` is low for exactly 1 cycle each.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state enum, default widths and host request struct for the data-memory arbiter
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 8;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} arb_state_e;
  typedef struct packed {
    logic we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } host_req_t;
endpackage

// File: rtl/dmem_arb_req_buf.sv
// dmem_arb_req_buf: one-entry host request buffer; ports clk/rst_n, load/clr controls, we/addr/wdata in, valid plus buf_we/buf_addr/buf_wdata out
module dmem_arb_req_buf
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid     <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      buf_we    <= we;
      buf_addr  <= addr;
      buf_wdata <= wdata;
    end else if (clr) valid <= 1'b0;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data memory between core (core_*, priority, core_stall) and host (host_* request/response), drives mem_*; DMEM_ARB_STATS_EN adds stat_steal_cnt/stat_force_cnt
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_steal_cnt,
  output logic [15:0]       stat_force_cnt
`endif
);
  localparam int WCW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  arb_state_e state_q, state_d;
  logic [WCW-1:0] wait_cnt;
  logic accept, at_max, steal, forced, host_acc;
  logic buf_valid, buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  dmem_arb_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .load(accept), .clr(host_acc),
    .we(host_we), .addr(host_addr), .wdata(host_wdata),
    .valid(buf_valid), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata)
  );
  assign host_ready = state_q == IDLE;
  assign accept     = host_valid && host_ready;
  assign at_max     = wait_cnt == WCW'(MAX_WAIT - 1);
  assign steal      = state_q == PEND && !core_req;
  assign forced     = state_q == FORCE;
  assign host_acc   = buf_valid && (steal || forced);
  assign core_stall = forced;
  assign core_rdata = mem_rdata;
  assign mem_we     = host_acc ? buf_we : core_we & core_req;
  assign mem_addr   = host_acc ? buf_addr : core_addr;
  assign mem_wdata  = host_acc ? buf_wdata : core_wdata;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (accept ? PEND : IDLE)
            : state_q == PEND ? (!core_req ? IDLE : at_max ? FORCE : PEND)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_cnt       <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt       <= accept ? '0 : (state_q == PEND && core_req && !at_max) ? wait_cnt + WCW'(1) : wait_cnt;
      host_rsp_valid <= host_acc;
      host_rsp_data  <= (host_acc && !buf_we) ? mem_rdata : '0;
    end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_steal_cnt <= '0;
      stat_force_cnt <= '0;
    end else begin
      stat_steal_cnt <= stat_steal_cnt + 16'((host_acc && steal) && !(&stat_steal_cnt));
      stat_force_cnt <= stat_force_cnt + 16'(forced && !(&stat_force_cnt));
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random checks of dmem_arbiter against a cycle-level behavioural model and a memory model
module tb_dmem_arbiter;
  localparam int MW = 8;
  logic clk = 0, rst_n = 0;
  logic core_req = 0, core_we = 0, core_stall;
  logic [31:0] core_addr = 0, core_wdata = 0, core_rdata;
  logic host_valid = 0, host_ready, host_we = 0, host_rsp_valid;
  logic [31:0] host_addr = 0, host_wdata = 0, host_rsp_data;
  logic mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int total = 0, bad = 0;
  bit pend = 0;
  int busy = 0, cyc_no = 0, acc_at = 0, stall_at = 0, nstall = 0;
  logic r_we = 0;
  logic [31:0] r_addr = 0, r_wdata = 0, exp_d = 0, last_rsp = 0;
  logic exp_v = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic hv, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
    logic stall_e, hg, ewe, acc;
    logic [31:0] ea;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_valid = hv; host_we = hw; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    stall_e = pend && busy == MW;
    hg = pend && (stall_e || !cr);
    acc = !pend && hv;
    ea = hg ? r_addr : ca;
    ewe = hg ? r_we : (cr && cw);
    chk("host_ready", host_ready, !pend);
    chk("core_stall", core_stall, stall_e);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    if (ewe) chk("mem_wdata", mem_wdata, hg ? r_wdata : cd);
    if (!hg && cr) chk("core_rdata", core_rdata, ref_mem[ca[7:0]]);
    chk("rsp_valid", host_rsp_valid, exp_v);
    chk("rsp_data", host_rsp_data, exp_d);
    if (host_rsp_valid) last_rsp = host_rsp_data;
    if (core_stall) begin nstall++; stall_at = cyc_no; end
    exp_v = hg;
    exp_d = (hg && !r_we) ? ref_mem[r_addr[7:0]] : 32'h0;
    if (ewe) ref_mem[ea[7:0]] = hg ? r_wdata : cd;
    if (hg) pend = 0;
    else if (pend && cr) busy++;
    if (acc) begin
      pend = 1; busy = 0; r_we = hw; r_addr = ha; r_wdata = hd; acc_at = cyc_no;
    end
    cyc_no++;
    @(posedge clk); #1;
  endtask
  initial begin
    int nmis;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    core_addr = 32'h44;
    @(negedge clk);
    chk("rst_ready", host_ready, 1);
    chk("rst_stall", core_stall, 0);
    chk("rst_rsp_valid", host_rsp_valid, 0);
    chk("rst_rsp_data", host_rsp_data, 0);
    chk("rst_mem_addr", mem_addr, 32'h44);
    @(posedge clk); #1 rst_n = 1;
    nstall = 0;
    step(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_no_stall", nstall, 0);
    chk("wr_mem10", mem[8'h10], 32'hDEADBEEF);
    nstall = 0;
    step(1, 0, 32'h4, 0, 1, 0, 32'h10, 0);
    repeat (11) step(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("force_stall_cnt", nstall, 1);
    chk("force_stall_at", stall_at - acc_at, MW + 1);
    chk("force_rd_data", last_rsp, 32'hDEADBEEF);
    nstall = 0;
    step(0, 0, 0, 0, 1, 0, 32'h10, 0);
    repeat (3) step(1, 0, 32'h8, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("steal_no_stall", nstall, 0);
    step(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0);
    nstall = 0;
    step(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
    for (int i = 1; i <= MW + 2; i++) step(1, i == MW + 1, 32'h20, 32'hBAD0BAD0, 0, 0, 0, 0);
    chk("force_we_mem20", mem[8'h20], 32'h12345678);
    chk("force_we_stall", nstall, 1);
    step(1, 0, 32'h4, 0, 1, 1, 32'h50, 32'h77);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("rst_pend_ready", host_ready, 1);
    chk("rst_pend_rsp", host_rsp_valid, 0);
    pend = 0; busy = 0; exp_v = 0; exp_d = 0;
    #1 rst_n = 1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_dropped_mem50", mem[8'h50], 0);
    step(0, 0, 0, 0, 1, 1, 32'h40, 32'hA1A1A1A1);
    step(0, 0, 0, 0, 1, 1, 32'h40, 32'hA1A1A1A1);
    step(0, 0, 0, 0, 1, 0, 32'h40, 0);
    step(0, 0, 0, 0, 1, 0, 32'h40, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_rd_data", last_rsp, 32'hA1A1A1A1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)), $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)), $urandom);
    repeat (MW + 3) step(0, 0, 0, 0, 0, 0, 0, 0);
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_contents", nmis, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
